// File: rtl/pong_frame_renderer.sv
// Pong display back end: VGA raster timing, per-frame position latch and sprite/decor colour mux.
// Latency: sync/de/rgb appear 2 clocks after their counter value; free-running, no backpressure.
module pong_frame_renderer #(
    parameter int H_RES         = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_RES         = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter int RGB_W         = 12,
    parameter logic [RGB_W-1:0] FG_COLOR    = 12'hFFF,
    parameter logic [RGB_W-1:0] DECOR_COLOR = 12'h888,
    parameter int X_POS_W       = 10,
    parameter int Y_POS_W       = 10,
    parameter int BALL_SIDE     = 8,
    parameter int PADDLE_WIDTH  = 8,
    parameter int PADDLE_HEIGHT = 64,
    parameter int SCREEN_BORDER = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [X_POS_W-1:0] player_x_i,
    input  logic [Y_POS_W-1:0] player_y_i,
    input  logic [X_POS_W-1:0] enemy_x_i,
    input  logic [Y_POS_W-1:0] enemy_y_i,
    input  logic [X_POS_W-1:0] ball_x_i,
    input  logic [Y_POS_W-1:0] ball_y_i,
    output logic               new_frame_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               de_o,
    output logic [RGB_W-1:0]   rgb_o
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);

    localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_VIS  = HC_W'(H_RES);
    localparam logic [HC_W-1:0] HS_BEG = HC_W'(H_RES + H_FP);
    localparam logic [HC_W-1:0] HS_END = HC_W'(H_RES + H_FP + H_SYNC);
    localparam logic [VC_W-1:0] V_LAST = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_VIS  = VC_W'(V_RES);
    localparam logic [VC_W-1:0] VS_BEG = VC_W'(V_RES + V_FP);
    localparam logic [VC_W-1:0] VS_END = VC_W'(V_RES + V_FP + V_SYNC);

    // Compare width has two spare bits so sx+W never wraps back onto the screen.
    localparam int CW_CNT = (HC_W > VC_W) ? HC_W : VC_W;
    localparam int CW_POS = (X_POS_W > Y_POS_W) ? X_POS_W : Y_POS_W;
    localparam int CW     = ((CW_CNT > CW_POS) ? CW_CNT : CW_POS) + 2;

    localparam logic [CW-1:0] BALL_C  = CW'(BALL_SIDE);
    localparam logic [CW-1:0] PAD_W_C = CW'(PADDLE_WIDTH);
    localparam logic [CW-1:0] PAD_H_C = CW'(PADDLE_HEIGHT);
    localparam logic [CW-1:0] BRD_LO  = CW'(SCREEN_BORDER);
    localparam logic [CW-1:0] BRD_HI  = CW'(V_RES - SCREEN_BORDER);
    localparam logic [CW-1:0] MID_L   = CW'(H_RES / 2 - 1);
    localparam logic [CW-1:0] MID_R   = CW'(H_RES / 2);

    function automatic logic in_rect(
        input logic [CW-1:0] x,
        input logic [CW-1:0] y,
        input logic [CW-1:0] sx,
        input logic [CW-1:0] sy,
        input logic [CW-1:0] w,
        input logic [CW-1:0] h
    );
        return (x >= sx) && (x < sx + w) && (y >= sy) && (y < sy + h);
    endfunction

    logic [HC_W-1:0]    h_cnt;
    logic [VC_W-1:0]    v_cnt;
    logic [X_POS_W-1:0] sh_player_x, sh_enemy_x, sh_ball_x;
    logic [Y_POS_W-1:0] sh_player_y, sh_enemy_y, sh_ball_y;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    logic frame_start;
    assign frame_start = (h_cnt == '0) && (v_cnt == V_VIS);

    // Positions are frozen for a whole frame so mid-frame updates cannot tear the picture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            new_frame_o <= 1'b0;
            sh_player_x <= '0;
            sh_player_y <= '0;
            sh_enemy_x  <= '0;
            sh_enemy_y  <= '0;
            sh_ball_x   <= '0;
            sh_ball_y   <= '0;
        end else begin
            new_frame_o <= frame_start;
            if (frame_start) begin
                sh_player_x <= player_x_i;
                sh_player_y <= player_y_i;
                sh_enemy_x  <= enemy_x_i;
                sh_enemy_y  <= enemy_y_i;
                sh_ball_x   <= ball_x_i;
                sh_ball_y   <= ball_y_i;
            end
        end
    end

    logic [CW-1:0] px, py;
    logic          visible, hs_raw, vs_raw;
    logic          ball_hit, paddle_hit, border_hit, centre_hit;

    assign px      = CW'(h_cnt);
    assign py      = CW'(v_cnt);
    assign visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs_raw  = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    assign vs_raw  = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));

    assign ball_hit   = in_rect(px, py, CW'(sh_ball_x), CW'(sh_ball_y), BALL_C, BALL_C);
    assign paddle_hit = in_rect(px, py, CW'(sh_player_x), CW'(sh_player_y), PAD_W_C, PAD_H_C)
                      | in_rect(px, py, CW'(sh_enemy_x), CW'(sh_enemy_y), PAD_W_C, PAD_H_C);
    assign border_hit = (py < BRD_LO) || (py >= BRD_HI);
    assign centre_hit = ((px == MID_L) || (px == MID_R)) && (py[4] == 1'b0);

    logic vis_q, hs_q, vs_q, ball_q, paddle_q, border_q, centre_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vis_q    <= 1'b0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            ball_q   <= 1'b0;
            paddle_q <= 1'b0;
            border_q <= 1'b0;
            centre_q <= 1'b0;
        end else begin
            vis_q    <= visible;
            hs_q     <= hs_raw;
            vs_q     <= vs_raw;
            ball_q   <= ball_hit;
            paddle_q <= paddle_hit;
            border_q <= border_hit;
            centre_q <= centre_hit;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hsync_o <= 1'b1;
            vsync_o <= 1'b1;
            de_o    <= 1'b0;
            rgb_o   <= '0;
        end else begin
            hsync_o <= hs_q;
            vsync_o <= vs_q;
            de_o    <= vis_q;
            if (!vis_q) begin
                rgb_o <= '0;
            end else if (ball_q) begin
                rgb_o <= FG_COLOR;
            end else if (paddle_q) begin
                rgb_o <= FG_COLOR;
            end else if (border_q) begin
                rgb_o <= DECOR_COLOR;
            end else if (centre_q) begin
                rgb_o <= DECOR_COLOR;
            end else begin
                rgb_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pong_frame_renderer.sv
// Scoreboard bench for pong_frame_renderer on a reduced raster (80x55 clocks per frame).
module tb_pong_frame_renderer;

    localparam int HR = 64, HFP = 4, HSY = 8, HBP = 4;
    localparam int VR = 48, VFP = 2, VSY = 2, VBP = 3;
    localparam int HT = HR + HFP + HSY + HBP;
    localparam int VT = VR + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;
    localparam int BS = 4, PW = 2, PH = 12, SB = 2;
    localparam logic [11:0] FG  = 12'hFFF;
    localparam logic [11:0] DEC = 12'h888;
    localparam int NPROBE = 25;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] player_x = '0, player_y = '0, enemy_x = '0, enemy_y = '0, ball_x = '0, ball_y = '0;
    logic       new_frame_o, hsync_o, vsync_o, de_o;
    logic [11:0] rgb_o;

    always #5 clk = ~clk;

    pong_frame_renderer #(
        .H_RES(HR), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_RES(VR), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .RGB_W(12), .FG_COLOR(FG), .DECOR_COLOR(DEC),
        .X_POS_W(10), .Y_POS_W(10),
        .BALL_SIDE(BS), .PADDLE_WIDTH(PW), .PADDLE_HEIGHT(PH), .SCREEN_BORDER(SB)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .player_x_i(player_x), .player_y_i(player_y),
        .enemy_x_i(enemy_x), .enemy_y_i(enemy_y),
        .ball_x_i(ball_x), .ball_y_i(ball_y),
        .new_frame_o(new_frame_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .de_o(de_o), .rgb_o(rgb_o)
    );

    typedef struct {
        logic        hs, vs, de, nf;
        logic [11:0] rgb;
        int          f, x, y;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0, n_err = 0, probe_hits = 0;
    int   n, phase;
    bit   run = 0, probes_on = 0;
    int   sh_px, sh_py, sh_ex, sh_ey, sh_bx, sh_by;

    // Fixed-picture probes: frame index after release, pixel, required colour.
    int          pr_f[NPROBE] = '{0,0,0,0,0,0, 1,1,1,1,1,1,1, 2,2,2, 3,3,3,3,3,3,3,3,3};
    int          pr_x[NPROBE] = '{10,32,32,32,31,0, 10,14,13,10,2,61,62, 40,10,2, 50,53,51,52,5,5,5,6,7};
    int          pr_y[NPROBE] = '{20,0,10,20,40,47, 20,20,23,24,5,41,30, 20,20,5, 0,3,11,11,0,39,40,47,45};
    logic [11:0] pr_c[NPROBE] = '{12'h000,12'h888,12'h888,12'h000,12'h888,12'h888,
                                  12'hFFF,12'h000,12'hFFF,12'h000,12'hFFF,12'hFFF,12'h000,
                                  12'hFFF,12'h000,12'hFFF,
                                  12'hFFF,12'hFFF,12'hFFF,12'h000,12'h888,12'h000,12'hFFF,12'hFFF,12'h000};

    function automatic bit in_box(int x, int y, int sx, int sy, int w, int h);
        return x >= sx && x < sx + w && y >= sy && y < sy + h;
    endfunction

    function automatic logic [11:0] model_rgb(int x, int y);
        if (x >= HR || y >= VR) return 12'h000;
        if (in_box(x, y, sh_bx, sh_by, BS, BS)) return FG;
        if (in_box(x, y, sh_px, sh_py, PW, PH) || in_box(x, y, sh_ex, sh_ey, PW, PH)) return FG;
        if (y < SB || y >= VR - SB) return DEC;
        if ((x == HR / 2 - 1 || x == HR / 2) && ((y / 16) % 2 == 0)) return DEC;
        return 12'h000;
    endfunction

    function automatic logic [9:0] rnd_pos(int lim);
        if ($urandom_range(0, 7) == 0) return 10'($urandom_range(1016, 1023));
        return 10'($urandom_range(0, lim));
    endfunction

    task automatic check_idle(input string name);
        logic [15:0] got, want;
        got  = {hsync_o, vsync_o, de_o, new_frame_o, rgb_o};
        want = {1'b1, 1'b1, 1'b0, 1'b0, 12'h000};
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got {hs,vs,de,nf,rgb}=%h want %h", name, got, want);
        end
    endtask

    task automatic start_run();
        exp_t e;
        rst_n = 1'b1;
        exp_q.delete();
        sh_px = 0; sh_py = 0; sh_ex = 0; sh_ey = 0; sh_bx = 0; sh_by = 0;
        e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.nf = 1'b0; e.rgb = 12'h000;
        e.f = -1; e.x = -1; e.y = -1;
        exp_q.push_back(e);
        n = 0;
        run = 1;
    endtask

    // One clock of stimulus: drive inputs for the current raster position and
    // queue the outputs the display must show two clocks later.
    task automatic drive_one();
        int x, y, f, xn, yn;
        exp_t e;
        x = n % HT; y = (n / HT) % VT; f = n / FRAME;
        if (phase == 0 && f == 0) begin
            ball_x = 10; ball_y = 20; player_x = 2; player_y = 5; enemy_x = 60; enemy_y = 30;
        end else if (phase == 0 && f == 1) begin
            ball_x = (y >= 10) ? 10'd40 : 10'd10;
        end else if (phase == 0 && f == 2) begin
            ball_x = 50; ball_y = 0; enemy_x = 50; enemy_y = 0; player_x = 5; player_y = VR - 8;
        end else if (x == 0) begin
            ball_x = rnd_pos(HR + 8); ball_y = rnd_pos(VR + 8);
            player_x = rnd_pos(HR + 8); player_y = rnd_pos(VR + 8);
            enemy_x = rnd_pos(HR + 8); enemy_y = rnd_pos(VR + 8);
        end
        xn = (n + 1) % HT; yn = ((n + 1) / HT) % VT;
        e.hs  = !(x >= HR + HFP && x < HR + HFP + HSY);
        e.vs  = !(y >= VR + VFP && y < VR + VFP + VSY);
        e.de  = (x < HR && y < VR);
        e.nf  = (xn == 0 && yn == VR);
        e.rgb = model_rgb(x, y);
        e.f = f; e.x = x; e.y = y;
        exp_q.push_back(e);
        if (x == 0 && y == VR) begin
            sh_px = int'(player_x); sh_py = int'(player_y);
            sh_ex = int'(enemy_x);  sh_ey = int'(enemy_y);
            sh_bx = int'(ball_x);   sh_by = int'(ball_y);
        end
        n++;
        @(negedge clk);
    endtask

    // Monitor: every clock after release the DUT presents one pixel; pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (run) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL scoreboard_underflow: DUT output with no expected entry at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    if ({hsync_o, vsync_o, de_o, new_frame_o, rgb_o} !== {e.hs, e.vs, e.de, e.nf, e.rgb}) begin
                        n_err++;
                        $display("FAIL pixel f=%0d x=%0d y=%0d: got hs=%b vs=%b de=%b nf=%b rgb=%h, want hs=%b vs=%b de=%b nf=%b rgb=%h",
                                 e.f, e.x, e.y, hsync_o, vsync_o, de_o, new_frame_o, rgb_o,
                                 e.hs, e.vs, e.de, e.nf, e.rgb);
                    end
                    if (probes_on) begin
                        for (int i = 0; i < NPROBE; i++) begin
                            if (pr_f[i] == e.f && pr_x[i] == e.x && pr_y[i] == e.y) begin
                                probe_hits++;
                                n_vec++;
                                if (rgb_o !== pr_c[i]) begin
                                    n_err++;
                                    $display("FAIL probe f=%0d (%0d,%0d): got rgb=%h want %h",
                                             e.f, e.x, e.y, rgb_o, pr_c[i]);
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        phase = 0;
        repeat (4) @(negedge clk);
        check_idle("reset_hold");

        probes_on = 1;
        start_run();
        while (n != 6 * FRAME + 5 * HT + 30) drive_one();

        // Mid-line asynchronous reset while a visible pixel is on the output.
        run = 0;
        n_vec++;
        if (de_o !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_de: got de=%b want 1", de_o);
        end
        #1 rst_n = 1'b0;
        #1 check_idle("async_reset_no_edge");
        exp_q.delete();
        repeat (3) @(negedge clk);
        check_idle("async_reset_hold");

        n_vec++;
        if (probe_hits != NPROBE) begin
            n_err++;
            $display("FAIL probe_coverage: got %0d probes visited want %0d", probe_hits, NPROBE);
        end

        probes_on = 0;
        phase = 1;
        start_run();
        repeat (FRAME + 3 * HT) drive_one();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        run = 0;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d entries left want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pong_frame_renderer.md
Name: pong_frame_renderer

Overview:
- Display-side counterpart of the game state block.
- Generates VGA raster timing and issues the once-per-frame new_frame pulse that paces game updates.
- Consumes the player, enemy and ball positions and outputs per-pixel RGB with matched sync signals.
- Sits between the game state block and the board VGA pins.

Parameters:
- H_RES, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_RES, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- RGB_W, 12, colour width, 4:4:4 packed {R,G,B}
- FG_COLOR, 12'hFFF, paddle/ball colour
- DECOR_COLOR, 12'h888, border and centre-line colour

Ports:
- clk_i  in  1  pixel clock
- rst_ni  in  1  asynchronous active-low reset
- player_x_i  in  X_POS_W  player paddle left x
- player_y_i  in  Y_POS_W  player paddle top y
- enemy_x_i  in  X_POS_W  enemy paddle left x
- enemy_y_i  in  Y_POS_W  enemy paddle top y
- ball_x_i  in  X_POS_W  ball left x
- ball_y_i  in  Y_POS_W  ball top y
- new_frame_o  out  1  one-cycle pulse at start of vertical blank
- hsync_o  out  1  horizontal sync, active low
- vsync_o  out  1  vertical sync, active low
- de_o  out  1  active-video enable
- rgb_o  out  RGB_W  pixel colour

Behaviour:
- Reset is asynchronous, active-low: one clock, rst_ni.
- Reset values: h_cnt=0, v_cnt=0, hsync_o=1, vsync_o=1, de_o=0, rgb_o=0, new_frame_o=0, all shadow position registers=0.
- h_cnt counts 0..H_TOTAL-1, where H_TOTAL=H_RES+H_FP+H_SYNC+H_BP (800).
- At wrap, h_cnt returns to 0 and v_cnt increments; v_cnt counts 0..V_TOTAL-1 (525), then wraps to 0.
- Stage 0 (counters) produces the following raw signals:
  - visible = (h_cnt<H_RES) && (v_cnt<V_RES)
  - hs_raw low for h_cnt in [H_RES+H_FP, H_RES+H_FP+H_SYNC)
  - vs_raw low for v_cnt in [V_RES+V_FP, V_RES+V_FP+V_SYNC)
- new_frame_o:
  - Registered and asserted for exactly the one cycle after counters hold h_cnt=0, v_cnt=V_RES.
  - One pulse per frame; never asserted while visible.
- Shadow latch:
  - On the same clock edge that sets new_frame_o, all six position inputs are captured into shadow registers.
  - Rendering uses only shadow values, so input changes mid-frame never tear the picture.
  - The first frame after reset renders with zeros.
- Stage 1 (registered) computes hit flags from counters and shadows, using zero-extended widths with no wrap:
  - Rectangle hit: x in [sx, sx+W) and y in [sy, sy+H).
  - ball: W=H=BALL_SIDE.
  - paddles: W=PADDLE_WIDTH, H=PADDLE_HEIGHT.
  - border: y<SCREEN_BORDER or y>=V_RES-SCREEN_BORDER.
  - centre: x in {H_RES/2-1, H_RES/2} and y[4]==0 (16-line dashes).
- Stage 2 (registered) selects colour by priority: ball > player|enemy > border > centre > background 0.
  - rgb_o=0 whenever the delayed visible is 0.
- Latency: hsync_o, vsync_o, de_o and rgb_o all appear 2 cycles after the corresponding counter value. Sync and de are delayed through identical stages, so they stay aligned with rgb.
- Sprites partially beyond screen edges are clipped naturally; there is no wrap-around to the opposite edge.
- Reset asserted mid-frame clears everything immediately. After release, counting restarts at (0,0) and the first new_frame_o follows V_RES lines later.

Test Plan:
- Reset: hold rst_ni=0 -> hsync_o=1, vsync_o=1, de_o=0, rgb_o=0, new_frame_o=0. Release -> de_o first rises 2 cycles after release.
- Timing: run 2 frames -> hsync_o period 800 clks, low for 96 clks; vsync_o low 2 lines per 525; new_frame_o pulses exactly every 420000 clks; de_o high 640 clks per visible line.
- Shadow: ball_x_i=100, ball_y_i=200, then pass new_frame_o -> in the next frame, pixel (100,200) = FG_COLOR and pixel (100+BALL_SIDE,200) = background. Change ball_x_i to 300 mid-frame -> frame unchanged; the move appears only after the next pulse.
- Priority: ball overlapping enemy paddle and border row -> overlap pixels = FG_COLOR. Pixel (320,0) = DECOR_COLOR (border). Pixel (320,100) = DECOR_COLOR (centre dash, y[4]=0); pixel (320,116) = 0.
- Clipping: paddle y at V_RES-8 -> only 8 rows drawn; row 0 of the screen is not affected.
- Async reset mid-line at h_cnt=300 -> outputs clear without a clock edge; the counter restarts at 0 after release.
